expr_string_gen: RTL and testbench

Transmit-side counterpart of the character-stream recogniser. Takes a loaded list of single-digit BCD operands and `+`/`*` operators and emits the ASCII expression one byte per handshake (digit, op, digit, …, digit). It produces exactly the `[0-9]`, `*` (42), `+` (43) alphabet the recogniser consumes. It sits between the control/test logic and the recogniser's 8-bit `in` port.

---
 rtl/expr_pkg.sv | 25 ++
 rtl/expr_char_enc.sv | 26 ++
 rtl/expr_string_gen.sv | 165 ++++++++++++++++
 tb/tb_expr_string_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// expr_pkg: shared constants, state encoding and helpers for the ASCII
// expression string generator and its character encoder.
package expr_pkg;

  // ASCII codes of the alphabet the downstream recogniser consumes.
  localparam logic [7:0] ASC_0    = 8'd48;
  localparam logic [7:0] ASC_STAR = 8'd42;
  localparam logic [7:0] ASC_PLUS = 8'd43;

  // Largest legal BCD digit.
  localparam logic [3:0] BCD_MAX  = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    OP    = 2'd2,
    FIN   = 2'd3
  } state_e;

  // True when the nibble is a legal BCD digit.
  function automatic logic is_bcd(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/expr_char_enc.sv
// expr_char_enc: purely combinational mapping of (state, digit, op bit) to
// the ASCII byte offered on the character stream.
//   state_i : FSM state (expr_pkg::state_e encoding)
//   digit_i : BCD operand selected for this position
//   op_i    : operator bit, 0 = '+', 1 = '*'
//   ch_o    : ASCII byte; 0 in any non-emitting state
module expr_char_enc
  import expr_pkg::*;
(
  input  logic [1:0] state_i,
  input  logic [3:0] digit_i,
  input  logic       op_i,
  output logic [7:0] ch_o
);

  // Select the character for the current state; silent states output 0.
  always_comb begin
    ch_o = 8'd0;
    case (state_e'(state_i))
      DIGIT:   ch_o = ASC_0 + {4'd0, digit_i};
      OP:      ch_o = op_i ? ASC_STAR : ASC_PLUS;
      default: ch_o = 8'd0;
    endcase
  end

endmodule

// File: rtl/expr_string_gen.sv
// expr_string_gen: loads a list of BCD operands and +/* operators and emits
// the ASCII expression (digit, op, digit, ..., digit) one byte per
// valid/ready handshake.
//   clk, clr_n        : clock, asynchronous active-low reset
//   start             : load request, honoured only in IDLE
//   n_opnd            : operand count (1..MAX_OPND)
//   digits, ops       : operands (operand 0 first) and operators
//   ch, ch_valid      : offered byte and its qualifier
//   ch_ready          : sink acceptance
//   busy, done, err   : in flight / end-of-stream pulse / reject pulse
// All outputs come straight from flops; the next byte is computed from the
// next state so there is no added per-byte latency.
module expr_string_gen
  import expr_pkg::*;
#(
  parameter int MAX_OPND = 8
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    start,
  input  logic [3:0]              n_opnd,
  input  logic [4*MAX_OPND-1:0]   digits,
  input  logic [MAX_OPND-2:0]     ops,
  output logic [7:0]              ch,
  output logic                    ch_valid,
  input  logic                    ch_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int IDX_W = $clog2(MAX_OPND);
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*MAX_OPND-1:0]   digits_q, digits_d;
  logic [MAX_OPND-2:0]     ops_q, ops_d;
  logic [3:0]              n_q, n_d;
  logic [7:0]              ch_q, ch_d;
  logic                    ch_valid_q, ch_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    xfer_s;
  logic                    load_bad_s;
  logic [4*MAX_OPND-1:0]   dshift_s;
  logic [MAX_OPND-2:0]     oshift_s;
  logic [3:0]              sel_digit_s;
  logic                    sel_op_s;

  assign xfer_s = ch_valid_q & ch_ready;

  // Load validation: count in range and every used operand a legal digit.
  always_comb begin
    load_bad_s = (n_opnd == 4'd0) || (n_opnd > 4'(MAX_OPND));
    for (int i = 0; i < MAX_OPND; i++) begin
      load_bad_s = load_bad_s |
                   ((4'(i) < n_opnd) & ~is_bcd(digits[4*i +: 4]));
    end
  end

  // Next state, index, operand latches and pulse outputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    digits_d = digits_q;
    ops_d    = ops_q;
    n_d      = n_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && load_bad_s) begin
          err_d = 1'b1;
        end else if (start) begin
          digits_d = digits;
          ops_d    = ops;
          n_d      = n_opnd;
          idx_d    = '0;
          state_d  = DIGIT;
        end else begin
          state_d = IDLE;
        end
      end
      DIGIT: begin
        if (xfer_s && (4'(idx_q) == (n_q - 4'd1))) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else if (xfer_s) begin
          state_d = OP;
        end else begin
          state_d = DIGIT;
        end
      end
      OP: begin
        if (xfer_s) begin
          idx_d   = idx_q + IDX_ONE;
          state_d = DIGIT;
        end else begin
          state_d = OP;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand/operator for the next state, taken from the post-edge latches
  // so a freshly accepted load offers its first digit right away.
  always_comb begin
    dshift_s    = digits_d >> {idx_d, 2'b00};
    sel_digit_s = dshift_s[3:0];
    oshift_s    = ops_d >> idx_d;
    sel_op_s    = oshift_s[0];
    ch_valid_d  = (state_d == DIGIT) || (state_d == OP);
    busy_d      = (state_d != IDLE);
  end

  expr_char_enc u_enc (
    .state_i (state_d),
    .digit_i (sel_digit_s),
    .op_i    (sel_op_s),
    .ch_o    (ch_d)
  );

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      digits_q   <= '0;
      ops_q      <= '0;
      n_q        <= 4'd0;
      ch_q       <= 8'd0;
      ch_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      digits_q   <= digits_d;
      ops_q      <= ops_d;
      n_q        <= n_d;
      ch_q       <= ch_d;
      ch_valid_q <= ch_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ch       = ch_q;
  assign ch_valid = ch_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_expr_string_gen.sv
// Testbench for expr_string_gen: table of loads (including rejects and a
// backpressure case), random valid loads with random ready/start noise,
// and hand-written reset-mid-stream sequence. Expected byte streams come
// from a string-building model of the expression.
module tb_expr_string_gen;

  localparam int MAXN = 8;

  logic             clk = 1'b0;
  logic             clr_n = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       n_opnd = 4'd0;
  logic [4*MAXN-1:0] digits = '0;
  logic [MAXN-2:0]  ops = '0;
  logic [7:0]       ch;
  logic             ch_valid;
  logic             ch_ready = 1'b0;
  logic             busy;
  logic             done;
  logic             err;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  expr_string_gen #(.MAX_OPND(MAXN)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (start),
    .n_opnd   (n_opnd),
    .digits   (digits),
    .ops      (ops),
    .ch       (ch),
    .ch_valid (ch_valid),
    .ch_ready (ch_ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  n;
    logic [31:0] d;
    logic [6:0]  o;
    int          mode;     // 0 ready high, 1 random ready, 2 pattern 1,0,0
    logic        exp_err;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the expression string as ASCII, operand 0 first.
  function automatic void build(input logic [3:0] n, input logic [31:0] d,
                                input logic [6:0] o);
    logic [3:0] nib;
    exp_q.delete();
    for (int i = 0; i < int'(n); i++) begin
      nib = d[4*i +: 4];
      exp_q.push_back(8'd48 + {4'd0, nib});
      if (i < int'(n) - 1) exp_q.push_back(o[i] ? 8'd42 : 8'd43);
    end
  endfunction

  task automatic idle_outputs(input string tag);
    chk({tag, "_ch"}, ch, 0);
    chk({tag, "_valid"}, ch_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic run_load(input logic [3:0] n, input logic [31:0] d,
                          input logic [6:0] o, input int mode,
                          input logic exp_err);
    int len;
    int got;
    logic stall;
    logic [7:0] prev;
    start = 1'b1; n_opnd = n; digits = d; ops = o; ch_ready = 1'b1;
    step();
    start = 1'b0; n_opnd = 4'($urandom); digits = $urandom; ops = 7'($urandom);
    if (exp_err) begin
      chk("rej_err", err, 1);
      chk("rej_busy", busy, 0);
      chk("rej_valid", ch_valid, 0);
      step();
      chk("rej_err_pulse", err, 0);
      chk("rej_busy2", busy, 0);
      return;
    end
    build(n, d, o);
    len = exp_q.size();
    chk("load_busy", busy, 1);
    got = 0; stall = 1'b0; prev = 8'd0;
    for (int cyc = 0; cyc < 400 && got < len; cyc++) begin
      if (stall) chk("hold", ch, prev);
      chk("valid", ch_valid, 1);
      chk("done_early", done, 0);
      case (mode)
        0:       ch_ready = 1'b1;
        1:       ch_ready = 1'($urandom_range(0, 1));
        default: ch_ready = (cyc % 3 == 0);
      endcase
      // Noise on the load inputs; must be ignored while busy.
      start = 1'($urandom_range(0, 1));
      n_opnd = 4'($urandom_range(1, 8));
      digits = $urandom; ops = 7'($urandom);
      if (ch_valid && ch_ready) begin
        chk("byte", ch, exp_q[got]);
        got++;
        stall = 1'b0;
      end else begin
        stall = ch_valid;
        prev = ch;
      end
      step();
    end
    start = 1'b0; ch_ready = 1'b1;
    chk("xfer_count", got, len);
    chk("done_pulse", done, 1);
    chk("fin_valid", ch_valid, 0);
    chk("fin_busy", busy, 1);
    step();
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_valid", ch_valid, 0);
    chk("post_ch", ch, 0);
  endtask

  vec_t vecs[7];

  initial begin
    logic [31:0] rd;
    logic [3:0]  rn;

    vecs[0] = '{4'd1, 32'h0000_0009, 7'd0, 0, 1'b0};   // single operand
    vecs[1] = '{4'd0, 32'h0000_0123, 7'd0, 0, 1'b1};   // zero count
    vecs[2] = '{4'd3, 32'h0000_05A3, 7'd1, 0, 1'b1};   // used digit 10
    vecs[3] = '{4'd2, 32'h0000_0F34, 7'd1, 0, 1'b0};   // unused digit 15
    vecs[4] = '{4'd9, 32'h1234_5678, 7'd0, 0, 1'b1};   // count > max
    vecs[5] = '{4'd3, 32'h0000_0725, 7'b0000010, 2, 1'b0}; // backpressure
    vecs[6] = '{4'd8, 32'h9876_5430, 7'b1010011, 0, 1'b0}; // full length

    #2;
    idle_outputs("reset");
    @(negedge clk);
    clr_n = 1'b1;
    step();
    idle_outputs("idle");

    // Table vectors back-to-back: each start comes the cycle after done.
    for (int v = 0; v < 7; v++) begin
      run_load(vecs[v].n, vecs[v].d, vecs[v].o, vecs[v].mode, vecs[v].exp_err);
    end

    // Reset mid-stream after two bytes: outputs clear at once, no done.
    start = 1'b1; n_opnd = 4'd3; digits = 32'h0000_0725; ops = 7'b0000010;
    ch_ready = 1'b1;
    step();
    start = 1'b0;
    chk("rst_b0", ch, 53);
    step();
    chk("rst_b1", ch, 43);
    step();
    chk("rst_b2", ch, 50);
    clr_n = 1'b0;
    #2;
    idle_outputs("rst_async");
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rst_no_done", done, 0);
      chk("rst_no_valid", ch_valid, 0);
    end

    // Random valid loads with random ready and start noise.
    for (int t = 0; t < 20; t++) begin
      rn = 4'($urandom_range(1, MAXN));
      rd = '0;
      for (int i = 0; i < MAXN; i++) begin
        rd[4*i +: 4] = (i < int'(rn)) ? 4'($urandom_range(0, 9))
                                      : 4'($urandom_range(0, 15));
      end
      run_load(rn, rd, 7'($urandom), 1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
